// File: rtl/f_fetch_unit.sv
// f_fetch_unit
//   Holds the architectural fetch PC and reads instruction words from
//   instruction memory over a req/ack handshake. It presents the instruction
//   and its PC to the F/D register, holds them while the hazard unit stalls,
//   and flags fetch addresses that are misaligned or out of range.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   stall       hazard-unit stall; holds the PC and the presented instruction
//   Npc         next PC, loaded only when a presented instruction is accepted
//   im_ack      instruction memory has im_rdata valid this cycle
//   im_rdata    instruction word from memory
//   im_req      read request to instruction memory
//   im_addr     read address (always F_PC)
//   F_PC        PC of the presented instruction
//   F_Instr     presented instruction (0 when the address is illegal)
//   F_valid     F_PC / F_Instr are valid for the F/D register
//   F_addr_err  F_PC is misaligned or outside instruction memory
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | request issued this cycle; an ack in the same cycle bypasses
// WAIT   | request outstanding, address held until im_ack
// HOLD   | stalled with the instruction captured; no request issued
module f_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] Npc,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic        im_req,
   output logic [31:0] im_addr,
   output logic [31:0] F_PC,
   output logic [31:0] F_Instr,
   output logic        F_valid,
   output logic        F_addr_err
);

   localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold;
   logic        hold_valid;

   logic        err;
   logic        ack_ok;
   logic        valid_int;

   assign err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);

   // An ack only counts while a legal request is outstanding; acks in HOLD or
   // against an illegal address are ignored.
   assign ack_ok = ((state == S_FETCH) || (state == S_WAIT)) && !err && im_ack;

   // Illegal addresses are never requested: they present a nop at once.
   assign valid_int = (state == S_HOLD) || ((state == S_FETCH) && err) || ack_ok;

   // Outputs are gated by reset so the interface is quiet while it is held,
   // even though the state register already sits in FETCH at RESET_PC.
   always_comb begin
      im_req     = 1'b0;
      F_valid    = 1'b0;
      F_Instr    = 32'h0;
      F_addr_err = 1'b0;
      if (reset) begin
         im_req     = ((state == S_FETCH) && !err) || (state == S_WAIT);
         F_valid    = valid_int;
         F_addr_err = err;
         if (!err) begin
            if (state == S_HOLD)
               F_Instr = hold_valid ? hold : 32'h0;
            else if (ack_ok)
               F_Instr = im_rdata;
         end
      end
   end

   assign im_addr = pc;
   assign F_PC    = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         hold       <= 32'h0;
         hold_valid <= 1'b0;
      end else if (valid_int) begin
         if (!stall) begin
            pc         <= Npc;
            hold_valid <= 1'b0;
            state      <= S_FETCH;
         end else begin
            if (ack_ok) begin
               hold       <= im_rdata;
               hold_valid <= 1'b1;
            end
            state <= S_HOLD;
         end
      end else if (state == S_FETCH) begin
         state <= S_WAIT;
      end
   end

endmodule

// File: tb/tb_f_fetch_unit.sv
module tb_f_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] Npc;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic        im_req;
   logic [31:0] im_addr;
   logic [31:0] F_PC;
   logic [31:0] F_Instr;
   logic        F_valid;
   logic        F_addr_err;

   f_fetch_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .Npc        (Npc),
      .im_ack     (im_ack),
      .im_rdata   (im_rdata),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .F_PC       (F_PC),
      .F_Instr    (F_Instr),
      .F_valid    (F_valid),
      .F_addr_err (F_addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
      logic        req;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   function automatic logic [31:0] w(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   // One clock cycle of stimulus. Called just after a rising edge; returns
   // just after the next one. Presented cycles go to the scoreboard, the
   // rest are checked here at the falling edge.
   task automatic step(input logic st, input logic [31:0] npc, input logic ack,
                       input logic [31:0] rd, input logic ev, input logic ereq,
                       input logic [31:0] epc, input logic [31:0] einstr,
                       input logic eerr);
      exp_t e;
      stall    = st;
      Npc      = npc;
      im_ack   = ack;
      im_rdata = rd;
      if (ev) begin
         e.pc = epc; e.instr = einstr; e.err = eerr; e.req = ereq;
         sb.push_back(e);
         @(negedge clk);
      end else begin
         @(negedge clk);
         check("idle_valid", {31'b0, F_valid}, 32'd0);
         check("idle_req",   {31'b0, im_req},  {31'b0, ereq});
         check("idle_addr",  im_addr, epc);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented instruction against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && F_valid) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_valid: got F_valid=1 pc=%08h expected no instruction", F_PC);
            end else begin
               n_pass++;
               e = sb.pop_front();
               check("F_PC",       F_PC,    e.pc);
               check("F_Instr",    F_Instr, e.instr);
               check("F_addr_err", {31'b0, F_addr_err}, {31'b0, e.err});
               check("im_req",     {31'b0, im_req},     {31'b0, e.req});
               check("im_addr",    im_addr, e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; stall = 1'b0; Npc = 32'h0; im_ack = 1'b1; im_rdata = JUNK;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req",   {31'b0, im_req},     32'd0);
      check("rst_valid", {31'b0, F_valid},    32'd0);
      check("rst_instr", F_Instr,             32'h0);
      check("rst_err",   {31'b0, F_addr_err}, 32'd0);
      check("rst_pc",    F_PC,                32'h3000);
      @(posedge clk); #1;
      reset = 1'b1;

      // zero-wait streaming
      step(0, 32'h3004, 1, w(32'h3000), 1, 1, 32'h3000, w(32'h3000), 0);
      step(0, 32'h3008, 1, w(32'h3004), 1, 1, 32'h3004, w(32'h3004), 0);
      step(0, 32'h300C, 1, w(32'h3008), 1, 1, 32'h3008, w(32'h3008), 0);
      // two-cycle ack latency, stall during WAIT has no effect
      step(0, 32'h3010, 0, JUNK,        0, 1, 32'h300C, 32'h0, 0);
      step(1, 32'h3010, 0, JUNK,        0, 1, 32'h300C, 32'h0, 0);
      step(0, 32'h3010, 1, w(32'h300C), 1, 1, 32'h300C, w(32'h300C), 0);
      // ack with stall: capture, hold 3 cycles, Npc changes ignored until release
      step(1, 32'h9999_9990, 1, w(32'h3010), 1, 1, 32'h3010, w(32'h3010), 0);
      step(1, 32'h3020, 0, JUNK,        1, 0, 32'h3010, w(32'h3010), 0);
      step(1, 32'h3020, 1, JUNK,        1, 0, 32'h3010, w(32'h3010), 0);
      step(0, 32'h3040, 0, JUNK,        1, 0, 32'h3010, w(32'h3010), 0);
      // jump to illegal addresses
      step(0, 32'h3002, 1, w(32'h3040), 1, 1, 32'h3040, w(32'h3040), 0);
      step(0, 32'h2FFC, 1, JUNK,        1, 0, 32'h3002, 32'h0, 1);
      step(1, 32'h7000, 0, JUNK,        1, 0, 32'h2FFC, 32'h0, 1);
      step(0, 32'h7000, 0, JUNK,        1, 0, 32'h2FFC, 32'h0, 1);
      step(0, 32'h6FFC, 0, JUNK,        1, 0, 32'h7000, 32'h0, 1);
      // last legal word
      step(0, 32'h3010, 1, w(32'h6FFC), 1, 1, 32'h6FFC, w(32'h6FFC), 0);
      // reset in the middle of WAIT
      step(0, 32'h3014, 0, JUNK,        0, 1, 32'h3010, 32'h0, 0);
      reset = 1'b0;
      #1;
      check("midrst_pc",    F_PC,                32'h3000);
      check("midrst_req",   {31'b0, im_req},     32'd0);
      check("midrst_valid", {31'b0, F_valid},    32'd0);
      im_ack = 1'b1; im_rdata = w(32'h3010);
      @(posedge clk); #1;
      im_ack = 1'b0;
      reset = 1'b1;
      step(0, 32'h3004, 0, JUNK,        0, 1, 32'h3000, 32'h0, 0);
      step(0, 32'h3004, 1, w(32'h3000), 1, 1, 32'h3000, w(32'h3000), 0);
      step(0, 32'h3008, 1, w(32'h3004), 1, 1, 32'h3004, w(32'h3004), 0);

      im_ack = 1'b0; stall = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- F-stage fetch unit; consumer of the next-PC value produced by the D-stage next-PC logic.
- Holds the architectural PC register and issues word reads to instruction memory over a req/ack handshake.
- Buffers the returned instruction and presents it, with its PC, to the F/D pipeline register.
- Honours hazard-unit stalls and flags illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, number of 32-bit words in instruction memory; legal range is IM_BASE to IM_BASE+4*IM_WORDS-4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds PC and the presented instruction.
- Npc  in  32  next PC from the next-PC logic; F_PC+4 when no jump or branch is taken.
- im_ack  in  1  instruction memory has im_rdata valid this cycle.
- im_rdata  in  32  instruction word.
- im_req  out  1  read request.
- im_addr  out  32  word address; equals F_PC.
- F_PC  out  32  PC of the presented instruction.
- F_Instr  out  32  presented instruction.
- F_valid  out  1  F_Instr/F_PC are valid for the F/D register.
- F_addr_err  out  1  F_PC is misaligned or out of range.

Behaviour:
- Reset (asynchronous assert, synchronous release): PC=RESET_PC, state=FETCH, hold register=0, hold_valid=0.
- While reset is asserted: im_req=0, F_valid=0, F_Instr=0, F_addr_err=0, F_PC=RESET_PC.
- Address error: err = (F_PC[1:0]!=0) || F_PC<IM_BASE || F_PC>IM_BASE+4*IM_WORDS-4. F_addr_err=err, combinational from F_PC.
- States: FETCH, WAIT, HOLD.
- FETCH:
  - If err: im_req=0, F_valid=1, F_Instr=32'h0 (nop).
  - Otherwise: im_req=1, im_addr=F_PC.
  - If im_ack in the same cycle: F_Instr=im_rdata (combinational bypass), F_valid=1.
  - If no ack: F_valid=0, next state WAIT.
- WAIT:
  - im_req stays 1; im_addr stays stable.
  - F_valid=0 until im_ack, then behaves as the ack cycle in FETCH.
- Accept rule: in any cycle with F_valid=1 and stall=0, PC<=Npc, hold_valid<=0, next state FETCH.
- Stall capture: in any cycle with F_valid=1 and stall=1, PC is unchanged. If the instruction came from im_ack, hold<=im_rdata and hold_valid<=1. Next state HOLD.
- HOLD:
  - im_req=0; F_valid=1; F_Instr=hold (or 0 if err).
  - stall=0 leads to the accept rule.
- Stall while F_valid=0 (FETCH without ack, or WAIT): no effect. The request continues.
- Zero-wait memory with no stall gives throughput of 1 instruction/cycle. Latency from Npc to im_addr is 1 cycle.
- Handshake rule: once im_req rises, im_req and im_addr remain stable until im_ack, except on reset. im_ack while im_req=0 is ignored.
- Reset mid-WAIT abandons the request. Any ack arriving after reset release belongs to the RESET_PC request only if memory also reset; memory is reset by the same signal.
- Npc is sampled only on the accept rule. Npc changes during stall or HOLD have no effect.
- PC arithmetic is 32-bit with no wrap handling; out-of-range values are reported through err.

Test Plan:
- Reset release, zero-wait IM returning word at addr, stall=0, Npc=F_PC+4 → im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; F_valid=1 every cycle.
- IM acks 2 cycles after req at 0x3000 → F_valid=0 for 2 cycles, im_addr held at 0x3000, then F_Instr=im_rdata with F_valid=1, next im_addr 0x3004.
- Ack at 0x3004 with stall=1 for 3 cycles → HOLD: im_req=0, F_Instr stays the captured word, F_PC=0x3004. Stall drop → next im_addr=Npc.
- Npc=0x0000_3002 after a jump → F_addr_err=1, im_req=0, F_Instr=0, F_valid=1. Npc=0x2FFC and Npc=0x7000 (IM_WORDS=4096) also raise F_addr_err.
- reset asserted mid-WAIT at PC 0x3010 → F_PC=0x3000 immediately, im_req=0. After release, fetch restarts at 0x3000.
- Npc=0x3020 while stall=1, then Npc=0x3040 at stall release → PC loads 0x3040.
